multicycle_ctrl: RTL and testbench

Control FSM for the multicycle MIPS datapath. It takes the instruction opcode from the instruction register and sequences fetch, decode, execute, memory and write-back. Each step drives the datapath enables and mux selects, and stalls on a memory ready handshake. The `ALU_op_o` encoding matches the single-cycle control path, so the existing ALU_Ctrl is reused unchanged.

---
 rtl/multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for the multicycle MIPS datapath. It sequences fetch, decode,
//   execute, memory and write-back from the opcode held in the IR. It stalls
//   in FETCH, MEM_RD and MEM_WR until the memory handshake completes.
//   Outputs are decoded from the state register. Some outputs are also
//   qualified by mem_ready_i (Mealy terms). All outputs are forced low while
//   rst_i is high.
//
// Ports
//   clk_i, rst_i      : rising-edge clock, synchronous active-high reset
//   instr_op_i[5:0]   : opcode IR[31:26], valid from DECODE onward
//   zero_i            : ALU zero flag. The datapath uses it to qualify PCWriteCond_o
//   mem_ready_i       : memory finished the current access this cycle
//   PCWrite_o, PCWriteCond_o, PCSource_o[1:0]   : PC update control
//   IorD_o, MemRead_o, MemWrite_o, IRWrite_o    : memory / IR control
//   MemtoReg_o, RegDst_o, RegWrite_o            : register file control
//   ALUSrcA_o, ALUSrcB_o[1:0], ALU_op_o[2:0]    : ALU operand and op select
//   instr_done_o      : pulse on the last cycle of every instruction
//   illegal_o         : pulse in DECODE for an unsupported opcode
//   mem_err_o         : pulse when a memory wait reaches MEM_TIMEOUT cycles
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic [1:0] PCSource_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALU_op_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       mem_err_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_R_EXEC   = 4'd2,
    S_R_WB     = 4'd3,
    S_I_EXEC   = 4'd4,
    S_I_WB     = 4'd5,
    S_BRANCH   = 4'd6,
    S_JUMP     = 4'd7,
    S_MEM_ADDR = 4'd8,
    S_MEM_RD   = 4'd9,
    S_MEM_WB   = 4'd10,
    S_MEM_WR   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b110;

  // The counter holds the completed wait cycles before the current one.
  // The wait that brings the count to MEM_TIMEOUT is therefore the one
  // where the counter reads MEM_TIMEOUT-1.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       in_mem_state;
  logic       waiting;
  logic       timeout;

  // The datapath combines zero_i with PCWriteCond_o. The FSM never needs it.
  logic unused_zero;
  assign unused_zero = zero_i;

  assign in_mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign waiting      = in_mem_state && !mem_ready_i;
  assign timeout      = waiting && (wait_cnt == WAIT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      // Every wait state is entered from a non-waiting cycle, so clearing
      // whenever we are not waiting also covers "clear on entry".
      if (!waiting || timeout) wait_cnt <= '0;
      else                     wait_cnt <= wait_cnt + 4'd1;

      case (state)
        S_FETCH:  if (mem_ready_i) state <= S_DECODE;
        S_DECODE: begin
          case (instr_op_i)
            OP_RTYPE:        state <= S_R_EXEC;
            OP_ADDI, OP_SLTI: state <= S_I_EXEC;
            OP_BEQ:          state <= S_BRANCH;
            OP_LW, OP_SW:    state <= S_MEM_ADDR;
            OP_J:            state <= S_JUMP;
            default:         state <= S_FETCH;
          endcase
        end
        S_R_EXEC:   state <= S_R_WB;
        S_I_EXEC:   state <= S_I_WB;
        S_MEM_ADDR: state <= (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready_i) state <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready_i) state <= S_FETCH;
        default:    state <= S_FETCH;  // R_WB, I_WB, BRANCH, JUMP, MEM_WB
      endcase
    end
  end

  // NOTE: every output gets a default before the case. Without it, a state
  // that skips an output would infer a latch.
  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSource_o    = 2'b00;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALU_op_o      = ALU_ADD;
    instr_done_o  = 1'b0;
    illegal_o     = 1'b0;
    mem_err_o     = 1'b0;

    if (!rst_i) begin
      mem_err_o = timeout;
      case (state)
        S_FETCH: begin
          MemRead_o = 1'b1;
          ALUSrcB_o = 2'b01;
          IRWrite_o = mem_ready_i;
          PCWrite_o = mem_ready_i;
        end
        S_DECODE: begin
          ALUSrcB_o = 2'b11;
          case (instr_op_i)
            OP_RTYPE, OP_ADDI, OP_SLTI, OP_BEQ, OP_LW, OP_SW, OP_J: ;
            default: begin
              illegal_o    = 1'b1;
              instr_done_o = 1'b1;
            end
          endcase
        end
        S_R_EXEC: begin
          ALUSrcA_o = 1'b1;
          ALU_op_o  = ALU_RTYPE;
        end
        S_I_EXEC: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b10;
          ALU_op_o  = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_R_WB: begin
          RegDst_o     = 1'b1;
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        S_I_WB: begin
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA_o     = 1'b1;
          ALU_op_o      = ALU_SUB;
          PCWriteCond_o = 1'b1;
          PCSource_o    = 2'b01;
          instr_done_o  = 1'b1;
        end
        S_JUMP: begin
          PCWrite_o    = 1'b1;
          PCSource_o   = 2'b10;
          instr_done_o = 1'b1;
        end
        S_MEM_ADDR: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b10;
        end
        S_MEM_RD: begin
          MemRead_o = 1'b1;
          IorD_o    = 1'b1;
        end
        S_MEM_WB: begin
          MemtoReg_o   = 1'b1;
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite_o   = 1'b1;
          IorD_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Each instruction runs from its
// FETCH cycle (cycle 1) until instr_done_o, with a bounded cycle budget.
// The outputs seen in every cycle are recorded and compared afterwards
// against hand-derived values.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
  logic       instr_done_o, illegal_o, mem_err_o;
  logic [1:0] PCSource_o, ALUSrcB_o;
  logic [2:0] ALU_op_o;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o),
    .PCSource_o(PCSource_o), .IorD_o(IorD_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o), .MemtoReg_o(MemtoReg_o),
    .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o),
    .ALUSrcB_o(ALUSrcB_o), .ALU_op_o(ALU_op_o), .instr_done_o(instr_done_o),
    .illegal_o(illegal_o), .mem_err_o(mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;
  localparam int         MAX_CYC  = 64;

  typedef struct packed {
    logic       done, rw, rd, m2r, irw, pcw, pcwc, ill, mrd, mwr, iord, err;
    logic [1:0] pcsrc, srcb;
    logic [2:0] aluop;
  } obs_t;

  obs_t trace [MAX_CYC];
  int   done_cyc, ir_cnt, err_cnt, err_cyc;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [19:0] all_outs;
  assign all_outs = {PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, MemRead_o,
                     MemWrite_o, IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o,
                     ALUSrcA_o, ALUSrcB_o, ALU_op_o, instr_done_o, illegal_o,
                     mem_err_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one instruction starting in FETCH. The task drives mem_ready_i low
  // for fw cycles in FETCH. For memory ops it also drives mem_ready_i low
  // for mw cycles in MEM_RD/MEM_WR. Everywhere else mem_ready_i is high,
  // which also shows that it is ignored outside the wait states.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input bit is_mem, input logic z);
    done_cyc = 0; ir_cnt = 0; err_cnt = 0; err_cyc = 0;
    for (int c = 1; c < MAX_CYC && done_cyc == 0; c++) begin
      instr_op_i  = op;
      zero_i      = z;
      mem_ready_i = !((c <= fw) || (is_mem && c >= fw + 4 && c < fw + 4 + mw));
      @(negedge clk_i);
      trace[c] = '{done: instr_done_o, rw: RegWrite_o, rd: RegDst_o, m2r: MemtoReg_o,
                   irw: IRWrite_o, pcw: PCWrite_o, pcwc: PCWriteCond_o, ill: illegal_o,
                   mrd: MemRead_o, mwr: MemWrite_o, iord: IorD_o, err: mem_err_o,
                   pcsrc: PCSource_o, srcb: ALUSrcB_o, aluop: ALU_op_o};
      if (instr_done_o) done_cyc = c;
      if (IRWrite_o) ir_cnt++;
      if (mem_err_o) begin err_cnt++; err_cyc = c; end
      @(posedge clk_i); #1;
    end
  endtask

  logic acc;

  initial begin
    rst_i = 1'b1; mem_ready_i = 1'b1; instr_op_i = OP_RTYPE; zero_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("reset_outputs_zero", 32'(all_outs), 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // R-type, zero wait: done in cycle 4, RegWrite/RegDst only in cycle 4.
    run_instr(OP_RTYPE, 0, 0, 1'b0, 1'b0);
    check("rtype_fetch_memread", 32'(trace[1].mrd), 32'h1);
    check("rtype_fetch_srcb",    32'(trace[1].srcb), 32'h1);
    check("rtype_decode_srcb",   32'(trace[2].srcb), 32'h3);
    check("rtype_done_cycle",    32'(done_cyc), 32'd4);
    check("rtype_aluop_c3",      32'(trace[3].aluop), 32'h6);
    acc = trace[1].rw | trace[2].rw | trace[3].rw | trace[1].rd | trace[2].rd | trace[3].rd;
    check("rtype_no_early_write", 32'(acc), 32'h0);
    check("rtype_wb_c4", 32'({trace[4].rw, trace[4].rd, trace[4].m2r}), 32'h6);

    // lw with 2 FETCH waits and 3 MEM_RD waits: done in cycle 10.
    run_instr(OP_LW, 2, 3, 1'b1, 1'b0);
    check("lw_done_cycle", 32'(done_cyc), 32'd10);
    check("lw_irwrite_once", 32'(ir_cnt), 32'd1);
    check("lw_irwrite_c3", 32'(trace[3].irw), 32'h1);
    acc = trace[6].mrd & trace[7].mrd & trace[8].mrd & trace[9].mrd &
          trace[6].iord & trace[9].iord;
    check("lw_memread_held", 32'(acc), 32'h1);
    check("lw_wb_c10", 32'({trace[10].m2r, trace[10].rw, trace[10].rd}), 32'h6);

    // beq with zero_i high and then low: identical control, 3-cycle latency.
    for (int z = 1; z >= 0; z--) begin
      run_instr(OP_BEQ, 0, 0, 1'b0, 1'(z));
      check($sformatf("beq_z%0d_done_cycle", z), 32'(done_cyc), 32'd3);
      check($sformatf("beq_z%0d_c3", z),
            32'({trace[3].pcwc, trace[3].pcsrc, trace[3].aluop, trace[3].pcw}),
            32'({1'b1, 2'b01, 3'b001, 1'b0}));
    end

    // Illegal opcode, then j. FETCH after the illegal one is the j's cycle 1.
    run_instr(OP_BAD, 0, 0, 1'b0, 1'b0);
    check("illegal_done_cycle", 32'(done_cyc), 32'd2);
    check("illegal_pulse_c2", 32'(trace[2].ill), 32'h1);
    run_instr(OP_J, 0, 0, 1'b0, 1'b0);
    check("after_illegal_fetch", 32'({trace[1].mrd, trace[1].irw}), 32'h3);
    check("j_done_cycle", 32'(done_cyc), 32'd3);
    check("j_c3", 32'({trace[3].pcw, trace[3].pcsrc, trace[3].pcwc}), 32'({1'b1, 2'b10, 1'b0}));

    // addi / slti select ADD / SLT with the immediate operand.
    run_instr(OP_ADDI, 0, 0, 1'b0, 1'b0);
    check("addi_c3", 32'({trace[3].aluop, trace[3].srcb}), 32'({3'b000, 2'b10}));
    check("addi_wb_c4", 32'({done_cyc[3:0], trace[4].rw, trace[4].rd}), 32'({4'd4, 1'b1, 1'b0}));
    run_instr(OP_SLTI, 0, 0, 1'b0, 1'b0);
    check("slti_c3", 32'({trace[3].aluop, trace[3].srcb}), 32'({3'b101, 2'b10}));

    // sw with one MEM_WR wait: 4 + 1 cycles, MemWrite held over the wait.
    run_instr(OP_SW, 0, 1, 1'b1, 1'b0);
    check("sw_done_cycle", 32'(done_cyc), 32'd5);
    check("sw_memwrite_c4_c5", 32'({trace[4].mwr, trace[5].mwr, trace[4].done}), 32'h6);

    // Timeout: 20 FETCH waits, single mem_err pulse at wait 15, then completes.
    run_instr(OP_RTYPE, 20, 0, 1'b0, 1'b0);
    check("timeout_err_count", 32'(err_cnt), 32'd1);
    check("timeout_err_cycle", 32'(err_cyc), 32'd15);
    check("timeout_done_cycle", 32'(done_cyc), 32'd24);
    check("timeout_memread_held", 32'(trace[20].mrd & trace[15].mrd), 32'h1);

    // Reset during MEM_WR with mem_ready_i low.
    instr_op_i = OP_SW; zero_i = 1'b0; mem_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 mem_ready_i = 1'b0;
    @(negedge clk_i);
    check("midrst_in_memwr", 32'(MemWrite_o), 32'h1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_outputs_zero", 32'(all_outs), 32'h0);
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    check("midrst_outputs_zero_ready", 32'(all_outs), 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    run_instr(OP_SW, 0, 0, 1'b1, 1'b0);
    check("postrst_fetch", 32'({trace[1].mrd, trace[1].mwr, trace[1].iord}), 32'h4);
    check("postrst_sw_done_cycle", 32'(done_cyc), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
